// File: rtl/totalzeros_dec_if.sv
// Handshake and bitstream bundle for the total_zeros decoder.
// The chroma_dc select exists only when TZ_DC_CHROMA_EN is defined.
interface totalzeros_dec_if;
  logic       start;
  logic [3:0] totalcoeff;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       dout_valid;
  logic       dout_ready;
  logic [3:0] totalzero;
  logic [3:0] CodeLength;
  logic       err;
`ifdef TZ_DC_CHROMA_EN
  logic       chroma_dc;

  modport master (
    output start, totalcoeff, bit_valid, bit_in, dout_ready, chroma_dc,
    input  bit_ready, dout_valid, totalzero, CodeLength, err
  );
  modport slave (
    input  start, totalcoeff, bit_valid, bit_in, dout_ready, chroma_dc,
    output bit_ready, dout_valid, totalzero, CodeLength, err
  );
`else
  modport master (
    output start, totalcoeff, bit_valid, bit_in, dout_ready,
    input  bit_ready, dout_valid, totalzero, CodeLength, err
  );
  modport slave (
    input  start, totalcoeff, bit_valid, bit_in, dout_ready,
    output bit_ready, dout_valid, totalzero, CodeLength, err
  );
`endif
endinterface

// File: rtl/totalzeros_dec.sv
// Bit-serial H.264 CAVLC total_zeros decoder (4x4 tables, tzVlcIndex 1..15).
// Define TZ_DC_CHROMA_EN to add the 2x2 chroma-DC tables selected by chroma_dc.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | consuming bits until a codeword matches or 9 bits are seen
// DONE  | result held on dout_* until dout_ready
module totalzeros_dec (
  input  logic            clk,
  input  logic            rst,
  totalzeros_dec_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Lookup key is {length, code}; the code sits right-aligned with zeros above it.
  // Result bit 4 = hit, bits 3:0 = total_zeros.
  function automatic logic [4:0] lut_4x4(input logic [3:0] tc, input logic [12:0] k);
    logic [4:0] r;
    r = 5'h00;
    case (tc)
      4'd1: case (k)
        {4'd1,9'b1}: r = 5'h10;         {4'd3,9'b011}: r = 5'h11;       {4'd3,9'b010}: r = 5'h12;
        {4'd4,9'b0011}: r = 5'h13;      {4'd4,9'b0010}: r = 5'h14;      {4'd5,9'b00011}: r = 5'h15;
        {4'd5,9'b00010}: r = 5'h16;     {4'd6,9'b000011}: r = 5'h17;    {4'd6,9'b000010}: r = 5'h18;
        {4'd7,9'b0000011}: r = 5'h19;   {4'd7,9'b0000010}: r = 5'h1a;   {4'd8,9'b00000011}: r = 5'h1b;
        {4'd8,9'b00000010}: r = 5'h1c;  {4'd9,9'b000000011}: r = 5'h1d; {4'd9,9'b000000010}: r = 5'h1e;
        {4'd9,9'b000000001}: r = 5'h1f;
        default: ;
      endcase
      4'd2: case (k)
        {4'd3,9'b111}: r = 5'h10;       {4'd3,9'b110}: r = 5'h11;       {4'd3,9'b101}: r = 5'h12;
        {4'd3,9'b100}: r = 5'h13;       {4'd3,9'b011}: r = 5'h14;       {4'd4,9'b0101}: r = 5'h15;
        {4'd4,9'b0100}: r = 5'h16;      {4'd4,9'b0011}: r = 5'h17;      {4'd4,9'b0010}: r = 5'h18;
        {4'd5,9'b00011}: r = 5'h19;     {4'd5,9'b00010}: r = 5'h1a;     {4'd6,9'b000011}: r = 5'h1b;
        {4'd6,9'b000010}: r = 5'h1c;    {4'd6,9'b000001}: r = 5'h1d;    {4'd6,9'b000000}: r = 5'h1e;
        default: ;
      endcase
      4'd3: case (k)
        {4'd4,9'b0101}: r = 5'h10;      {4'd3,9'b111}: r = 5'h11;       {4'd3,9'b110}: r = 5'h12;
        {4'd3,9'b101}: r = 5'h13;       {4'd4,9'b0100}: r = 5'h14;      {4'd4,9'b0011}: r = 5'h15;
        {4'd3,9'b100}: r = 5'h16;       {4'd3,9'b011}: r = 5'h17;       {4'd4,9'b0010}: r = 5'h18;
        {4'd5,9'b00011}: r = 5'h19;     {4'd5,9'b00010}: r = 5'h1a;     {4'd6,9'b000001}: r = 5'h1b;
        {4'd5,9'b00001}: r = 5'h1c;     {4'd6,9'b000000}: r = 5'h1d;
        default: ;
      endcase
      4'd4: case (k)
        {4'd5,9'b00011}: r = 5'h10;     {4'd3,9'b111}: r = 5'h11;       {4'd4,9'b0101}: r = 5'h12;
        {4'd4,9'b0100}: r = 5'h13;      {4'd3,9'b110}: r = 5'h14;       {4'd3,9'b101}: r = 5'h15;
        {4'd3,9'b100}: r = 5'h16;       {4'd4,9'b0011}: r = 5'h17;      {4'd3,9'b011}: r = 5'h18;
        {4'd4,9'b0010}: r = 5'h19;      {4'd5,9'b00010}: r = 5'h1a;     {4'd5,9'b00001}: r = 5'h1b;
        {4'd5,9'b00000}: r = 5'h1c;
        default: ;
      endcase
      4'd5: case (k)
        {4'd4,9'b0101}: r = 5'h10;      {4'd4,9'b0100}: r = 5'h11;      {4'd4,9'b0011}: r = 5'h12;
        {4'd3,9'b111}: r = 5'h13;       {4'd3,9'b110}: r = 5'h14;       {4'd3,9'b101}: r = 5'h15;
        {4'd3,9'b100}: r = 5'h16;       {4'd3,9'b011}: r = 5'h17;       {4'd4,9'b0010}: r = 5'h18;
        {4'd5,9'b00001}: r = 5'h19;     {4'd4,9'b0001}: r = 5'h1a;      {4'd5,9'b00000}: r = 5'h1b;
        default: ;
      endcase
      4'd6: case (k)
        {4'd6,9'b000001}: r = 5'h10;    {4'd5,9'b00001}: r = 5'h11;     {4'd3,9'b111}: r = 5'h12;
        {4'd3,9'b110}: r = 5'h13;       {4'd3,9'b101}: r = 5'h14;       {4'd3,9'b100}: r = 5'h15;
        {4'd3,9'b011}: r = 5'h16;       {4'd3,9'b010}: r = 5'h17;       {4'd4,9'b0001}: r = 5'h18;
        {4'd3,9'b001}: r = 5'h19;       {4'd6,9'b000000}: r = 5'h1a;
        default: ;
      endcase
      4'd7: case (k)
        {4'd6,9'b000001}: r = 5'h10;    {4'd5,9'b00001}: r = 5'h11;     {4'd3,9'b101}: r = 5'h12;
        {4'd3,9'b100}: r = 5'h13;       {4'd3,9'b011}: r = 5'h14;       {4'd2,9'b11}: r = 5'h15;
        {4'd3,9'b010}: r = 5'h16;       {4'd4,9'b0001}: r = 5'h17;      {4'd3,9'b001}: r = 5'h18;
        {4'd6,9'b000000}: r = 5'h19;
        default: ;
      endcase
      4'd8: case (k)
        {4'd6,9'b000001}: r = 5'h10;    {4'd4,9'b0001}: r = 5'h11;      {4'd5,9'b00001}: r = 5'h12;
        {4'd3,9'b011}: r = 5'h13;       {4'd2,9'b11}: r = 5'h14;        {4'd2,9'b10}: r = 5'h15;
        {4'd3,9'b010}: r = 5'h16;       {4'd3,9'b001}: r = 5'h17;       {4'd6,9'b000000}: r = 5'h18;
        default: ;
      endcase
      4'd9: case (k)
        {4'd6,9'b000001}: r = 5'h10;    {4'd6,9'b000000}: r = 5'h11;    {4'd4,9'b0001}: r = 5'h12;
        {4'd2,9'b11}: r = 5'h13;        {4'd2,9'b10}: r = 5'h14;        {4'd3,9'b001}: r = 5'h15;
        {4'd2,9'b01}: r = 5'h16;        {4'd5,9'b00001}: r = 5'h17;
        default: ;
      endcase
      4'd10: case (k)
        {4'd5,9'b00001}: r = 5'h10;     {4'd5,9'b00000}: r = 5'h11;     {4'd3,9'b001}: r = 5'h12;
        {4'd2,9'b11}: r = 5'h13;        {4'd2,9'b10}: r = 5'h14;        {4'd2,9'b01}: r = 5'h15;
        {4'd4,9'b0001}: r = 5'h16;
        default: ;
      endcase
      4'd11: case (k)
        {4'd4,9'b0000}: r = 5'h10;      {4'd4,9'b0001}: r = 5'h11;      {4'd3,9'b001}: r = 5'h12;
        {4'd3,9'b010}: r = 5'h13;       {4'd1,9'b1}: r = 5'h14;         {4'd3,9'b011}: r = 5'h15;
        default: ;
      endcase
      4'd12: case (k)
        {4'd4,9'b0000}: r = 5'h10;      {4'd4,9'b0001}: r = 5'h11;      {4'd2,9'b01}: r = 5'h12;
        {4'd1,9'b1}: r = 5'h13;         {4'd3,9'b001}: r = 5'h14;
        default: ;
      endcase
      4'd13: case (k)
        {4'd3,9'b000}: r = 5'h10;       {4'd3,9'b001}: r = 5'h11;       {4'd1,9'b1}: r = 5'h12;
        {4'd2,9'b01}: r = 5'h13;
        default: ;
      endcase
      4'd14: case (k)
        {4'd2,9'b00}: r = 5'h10;        {4'd2,9'b01}: r = 5'h11;        {4'd1,9'b1}: r = 5'h12;
        default: ;
      endcase
      4'd15: case (k)
        {4'd1,9'b0}: r = 5'h10;         {4'd1,9'b1}: r = 5'h11;
        default: ;
      endcase
      default: ;
    endcase
    return r;
  endfunction

`ifdef TZ_DC_CHROMA_EN
  function automatic logic [4:0] lut_cdc(input logic [3:0] tc, input logic [12:0] k);
    logic [4:0] r;
    r = 5'h00;
    case (tc)
      4'd1: case (k)
        {4'd1,9'b1}: r = 5'h10;   {4'd2,9'b01}: r = 5'h11;
        {4'd3,9'b001}: r = 5'h12; {4'd3,9'b000}: r = 5'h13;
        default: ;
      endcase
      4'd2: case (k)
        {4'd1,9'b1}: r = 5'h10;   {4'd2,9'b01}: r = 5'h11;  {4'd2,9'b00}: r = 5'h12;
        default: ;
      endcase
      4'd3: case (k)
        {4'd1,9'b1}: r = 5'h10;   {4'd1,9'b0}: r = 5'h11;
        default: ;
      endcase
      default: ;
    endcase
    return r;
  endfunction
`endif

  state_t     state_q;
  logic [3:0] tc_q;
  logic [8:0] sr_q;
  logic [3:0] cnt_q;
  logic       bit_ready_q;
  logic       dout_valid_q;
  logic [3:0] tz_q;
  logic [3:0] len_q;
  logic       err_q;
`ifdef TZ_DC_CHROMA_EN
  logic       chroma_q;
`endif

  logic [8:0] sr_d;
  logic [3:0] cnt_d;
  logic [4:0] lut;

  // Match includes the bit being consumed this cycle.
  assign sr_d  = (sr_q << 1) | {8'd0, bus.bit_in};
  assign cnt_d = cnt_q + 4'd1;

  always_comb begin
    lut = lut_4x4(tc_q, {cnt_d, sr_d});
`ifdef TZ_DC_CHROMA_EN
    if (chroma_q) lut = lut_cdc(tc_q, {cnt_d, sr_d});
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tc_q         <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      bit_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      tz_q         <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
`ifdef TZ_DC_CHROMA_EN
      chroma_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            tc_q  <= bus.totalcoeff;
            sr_q  <= '0;
            cnt_q <= '0;
            tz_q  <= '0;
            len_q <= '0;
            err_q <= 1'b0;
`ifdef TZ_DC_CHROMA_EN
            chroma_q <= bus.chroma_dc;
`endif
            if (bus.totalcoeff == 4'd0) begin
              state_q      <= DONE;
              dout_valid_q <= 1'b1;
            end
`ifdef TZ_DC_CHROMA_EN
            else if (bus.chroma_dc && (bus.totalcoeff > 4'd3)) begin
              state_q      <= DONE;
              dout_valid_q <= 1'b1;
              err_q        <= 1'b1;
            end
`endif
            else begin
              state_q     <= SHIFT;
              bit_ready_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bus.bit_valid) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            if (lut[4]) begin
              state_q      <= DONE;
              bit_ready_q  <= 1'b0;
              dout_valid_q <= 1'b1;
              tz_q         <= lut[3:0];
              len_q        <= cnt_d;
              err_q        <= 1'b0;
            end else if (cnt_d == 4'd9) begin
              state_q      <= DONE;
              bit_ready_q  <= 1'b0;
              dout_valid_q <= 1'b1;
              tz_q         <= '0;
              len_q        <= 4'd9;
              err_q        <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.dout_ready) begin
            state_q      <= IDLE;
            dout_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bit_ready  = bit_ready_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.totalzero  = tz_q;
  assign bus.CodeLength = len_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_totalzeros_dec.sv
// Directed bench for totalzeros_dec: expected results queued at stimulus, checked on dout_valid.
// Chroma-DC cases run only when TZ_DC_CHROMA_EN is defined.
module tb_totalzeros_dec;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [3:0] tz;
    logic [3:0] len;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  totalzeros_dec_if bus();

  totalzeros_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".dout_valid"}, {31'd0, bus.dout_valid}, 32'd0);
    check({tag, ".bit_ready"},  {31'd0, bus.bit_ready},  32'd0);
    check({tag, ".totalzero"},  {28'd0, bus.totalzero},  32'd0);
    check({tag, ".CodeLength"}, {28'd0, bus.CodeLength}, 32'd0);
    check({tag, ".err"},        {31'd0, bus.err},        32'd0);
  endtask

  // Wait (bounded) for dout_valid, then compare against the oldest queued result.
  task automatic collect(input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (bus.dout_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("dout_valid", {31'd0, bus.dout_valid}, 32'd1);
    e = exp_q.pop_front();
    check("totalzero",  {28'd0, bus.totalzero},  {28'd0, e.tz});
    check("CodeLength", {28'd0, bus.CodeLength}, {28'd0, e.len});
    check("err",        {31'd0, bus.err},        {31'd0, e.err});
  endtask

  task automatic ack();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    check("ack.dout_valid", {31'd0, bus.dout_valid}, 32'd0);
  endtask

  // bits holds nb codeword bits right-aligned, sent MSB first.
  task automatic decode(input logic [3:0] tc, input int nb, input logic [8:0] bits,
                        input int stall, input logic [3:0] etz, input logic [3:0] elen,
                        input logic eerr);
    logic [8:0] sh;
    exp_q.push_back('{tz: etz, len: elen, err: eerr});
    sh = bits << (9 - nb);
    bus.start      = 1'b1;
    bus.totalcoeff = tc;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stall; s++) begin
          bus.bit_valid = 1'b0;
          tick();
        end
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = sh[8];
      sh            = sh << 1;
      check("bit_ready", {31'd0, bus.bit_ready}, 32'd1);
      tick();
    end
    bus.bit_valid = 1'b0;
    collect(0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.totalcoeff = 4'd0;
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    bus.dout_ready = 1'b0;
`ifdef TZ_DC_CHROMA_EN
    bus.chroma_dc  = 1'b0;
`endif
    #12;
    check_idle_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick();

    decode(4'd9, 3, 9'b001, 0, 4'd5, 4'd3, 1'b0);
    ack();
    decode(4'd1, 9, 9'b000000001, 0, 4'd15, 4'd9, 1'b0);
    ack();
    decode(4'd1, 9, 9'b000000000, 0, 4'd0, 4'd9, 1'b1);
    ack();
    decode(4'd6, 3, 9'b111, 3, 4'd2, 4'd3, 1'b0);
    check("done.bit_ready", {31'd0, bus.bit_ready}, 32'd0);
    ack();

    // totalcoeff=0: immediate result, held while dout_ready stays low
    decode(4'd0, 0, 9'b0, 0, 4'd0, 4'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold.dout_valid", {31'd0, bus.dout_valid}, 32'd1);
      check("hold.totalzero",  {28'd0, bus.totalzero},  32'd0);
      check("hold.CodeLength", {28'd0, bus.CodeLength}, 32'd0);
      check("hold.bit_ready",  {31'd0, bus.bit_ready},  32'd0);
    end
    // start coincident with the handshake must be dropped
    bus.dout_ready = 1'b1;
    bus.start      = 1'b1;
    bus.totalcoeff = 4'd9;
    tick();
    bus.start      = 1'b0;
    bus.dout_ready = 1'b0;
    check("hs.dout_valid", {31'd0, bus.dout_valid}, 32'd0);
    tick();
    tick();
    check("hs.bit_ready",   {31'd0, bus.bit_ready},  32'd0);
    check("hs.dout_valid2", {31'd0, bus.dout_valid}, 32'd0);

    // reset after 2 of 3 bits
    bus.start      = 1'b1;
    bus.totalcoeff = 4'd9;
    tick();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b0;
    tick();
    tick();
    bus.bit_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_shift");
    rst = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("rst_shift.post_valid", {31'd0, bus.dout_valid}, 32'd0);
    check("rst_shift.post_ready", {31'd0, bus.bit_ready},  32'd0);
    decode(4'd9, 2, 9'b01, 0, 4'd6, 4'd2, 1'b0);
    ack();

    // reset while a result is pending
    bus.start      = 1'b1;
    bus.totalcoeff = 4'd15;
    tick();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    check("pend.dout_valid", {31'd0, bus.dout_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_done");
    rst = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("rst_done.post_valid", {31'd0, bus.dout_valid}, 32'd0);

    decode(4'd15, 1, 9'b0, 0, 4'd0, 4'd1, 1'b0);
    ack();
    decode(4'd4, 5, 9'b00000, 1, 4'd12, 4'd5, 1'b0);
    ack();
    decode(4'd2, 3, 9'b101, 0, 4'd2, 4'd3, 1'b0);
    ack();
    decode(4'd13, 3, 9'b000, 2, 4'd0, 4'd3, 1'b0);
    ack();
    decode(4'd11, 1, 9'b1, 0, 4'd4, 4'd1, 1'b0);
    ack();
    decode(4'd8, 6, 9'b000000, 0, 4'd8, 4'd6, 1'b0);
    ack();
    decode(4'd3, 6, 9'b000001, 0, 4'd11, 4'd6, 1'b0);
    ack();

`ifdef TZ_DC_CHROMA_EN
    bus.chroma_dc = 1'b1;
    decode(4'd1, 3, 9'b001, 0, 4'd2, 4'd3, 1'b0);
    ack();
    decode(4'd2, 2, 9'b00, 0, 4'd2, 4'd2, 1'b0);
    ack();
    decode(4'd3, 1, 9'b0, 0, 4'd1, 4'd1, 1'b0);
    ack();
    decode(4'd4, 0, 9'b0, 0, 4'd0, 4'd0, 1'b1);
    check("cdc_err.bit_ready", {31'd0, bus.bit_ready}, 32'd0);
    ack();
    bus.chroma_dc = 1'b0;
    decode(4'd1, 3, 9'b010, 0, 4'd2, 4'd3, 1'b0);
    ack();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
